slv_guard_chan_monitor: RTL and testbench
=========================================

SLV_GUARD_CHAN_MONITOR -- requirements
Module: slv_guard_chan_monitor

Interface
REQ-001 SHALL have parameter IdWidth, default 4, width of transaction ID.
REQ-002 SHALL have parameter MaxTxns, default 8, outstanding-transaction table depth (>=2).
REQ-003 SHALL have parameter CntWidth, default 10, width of per-slot age counters and budget.
REQ-004 SHALL have ports, in order:
- clk_i  in  1  clock; the only clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- guard_ena_i  in  1  enables tracking and fault handling.
- budget_i  in  CntWidth  timeout budget in cycles; 0 disables timeout.
- mst_req_valid_i / mst_req_ready_o  in/out  1  request handshake, manager side.
- mst_req_id_i  in  IdWidth  request ID.
- slv_req_valid_o / slv_req_ready_i  out/in  1  request handshake, subordinate side.
- slv_rsp_valid_i / slv_rsp_ready_o  in/out  1  response handshake, subordinate side.
- slv_rsp_id_i  in  IdWidth; slv_rsp_last_i  in  1  response ID, final beat.
- mst_rsp_valid_o / mst_rsp_ready_i  out/in  1  response handshake, manager side.
- mst_rsp_id_o  out  IdWidth; mst_rsp_last_o  out  1; mst_rsp_err_o  out  1  error response flag.
- irq_o  out  1  fault interrupt, level.
- rst_req_o  out  1  subordinate reset request.
- rst_stat_i  in  1  subordinate reset in progress.
- fault_id_o  out  IdWidth  ID of the faulting transaction.
- outstanding_o  out  $clog2(MaxTxns+1)  number of valid table slots.

Function
REQ-005 SHALL implement FSM states RUN, DRAIN, RESET, WAIT_CLR.
REQ-006 In RUN with guard_ena_i=0, SHALL pass all handshakes through combinationally, allocate nothing, and raise no faults.
REQ-007 In RUN with guard_ena_i=1:
- requests SHALL pass through unless the table is full;
- when full, mst_req_ready_o=0 and slv_req_valid_o=0.
REQ-008 A request handshake on the subordinate side SHALL allocate the lowest free slot with {id, age=0, seq=allocation order}.
REQ-009 A response handshake with last=1 SHALL free the oldest valid slot with a matching ID. last=0 beats SHALL only pass through.
REQ-010 Allocation and free in the same cycle SHALL both take effect. outstanding_o SHALL reflect the registered count.
REQ-011 Each valid slot's age SHALL increment by 1 per cycle and saturate at all-ones.
REQ-012 Timeout SHALL be detected when budget_i!=0 and a valid slot's age==budget_i.
REQ-013 A response handshake whose ID matches no valid slot SHALL be detected as an unmatched-response fault.
REQ-014 On any fault, the FSM SHALL enter DRAIN next cycle; irq_o=1 and fault_id_o is latched in that same cycle.
- Fault ID priority: timeout over unmatched.
- Among multiple timeouts, the lowest slot index wins.
REQ-015 In DRAIN:
- mst_req_ready_o=0, slv_req_valid_o=0, slv_rsp_ready_o=1; subordinate responses are sunk and not forwarded.
- SHALL emit one response per valid slot, oldest seq first, with mst_rsp_id_o=slot ID, last=1, err=1.
- A slot is freed on mst_rsp_ready_i.
- mst_rsp_valid_o SHALL stay stable until accepted.
REQ-016 When the table is empty in DRAIN, the FSM SHALL enter RESET and assert rst_req_o.
REQ-017 In RESET, the FSM SHALL enter WAIT_CLR when rst_stat_i=1.
REQ-018 In WAIT_CLR, when rst_stat_i=0 the FSM SHALL enter RUN and clear irq_o, rst_req_o and fault_id_o on the same edge.
REQ-019 Outside RUN, the mst_req and slv_rsp paths SHALL be isolated as in REQ-015 until RUN is re-entered.
REQ-020 guard_ena_i SHALL be sampled only in RUN. Deassertion in any other state SHALL not abort recovery.
REQ-021 A guard_ena_i 1->0 transition in RUN SHALL invalidate all slots on the next edge.

Reset
REQ-022 On rst_ni=0, the block SHALL asynchronously reset to:
- state RUN, all slots invalid, all ages 0, seq counter 0;
- irq_o=0, rst_req_o=0, fault_id_o=0, outstanding_o=0.
REQ-023 Reset mid-DRAIN SHALL abandon pending error responses without emitting partial handshakes after release.
REQ-024 The first request SHALL be accepted in the first cycle after rst_ni rises.

Verification
REQ-025 Pass-through scenario: guard_ena_i=0, 20 random requests and responses -> all outputs equal inputs; outstanding_o=0; irq_o=0.
REQ-026 Full-table scenario: MaxTxns=8, 8 requests with no responses, budget_i=0 -> outstanding_o=8; 9th request sees mst_req_ready_o=0; one last response frees a slot and the 9th is accepted next cycle.
REQ-027 Timeout scenario: budget_i=5, ID 3 issued, no response -> irq_o=1 and fault_id_o=3 exactly 6 cycles after acceptance; one err response with ID 3 emitted; then rst_req_o=1.
REQ-028 Drain-order scenario: IDs 1, 2, 1 issued, timeout on the first -> three err responses in order 1, 2, 1, with mst_rsp_ready_i stalled 2 cycles on each; valid held throughout.
REQ-029 Unmatched-response scenario: response ID 7 with no outstanding ID 7 -> DRAIN next cycle with fault_id_o=7; rst_stat_i pulse 1 for 3 cycles then 0 -> RUN with irq_o=0 and rst_req_o=0.
REQ-030 Mid-recovery reset scenario: rst_ni asserted during DRAIN with 2 slots pending -> all outputs at reset values immediately; no err responses after release.

Source files
------------

// File: rtl/slv_guard_chan_monitor.sv
// Channel guard between a manager and a subordinate: tracks outstanding request IDs,
// flags timeouts and unmatched responses, then drains error responses and sequences a subordinate reset.
//
// state    | meaning
// RUN      | normal forwarding; the table is tracked while guard_ena_i=1
// DRAIN    | manager side isolated; one error response is returned per outstanding slot
// RESET    | rst_req_o high; waiting for the subordinate to report reset in progress
// WAIT_CLR | waiting for the subordinate reset to finish before resuming
module slv_guard_chan_monitor #(
    parameter int IdWidth  = 4,
    parameter int MaxTxns  = 8,
    parameter int CntWidth = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         guard_ena_i,
    input  logic [CntWidth-1:0]          budget_i,
    input  logic                         mst_req_valid_i,
    output logic                         mst_req_ready_o,
    input  logic [IdWidth-1:0]           mst_req_id_i,
    output logic                         slv_req_valid_o,
    input  logic                         slv_req_ready_i,
    input  logic                         slv_rsp_valid_i,
    output logic                         slv_rsp_ready_o,
    input  logic [IdWidth-1:0]           slv_rsp_id_i,
    input  logic                         slv_rsp_last_i,
    output logic                         mst_rsp_valid_o,
    input  logic                         mst_rsp_ready_i,
    output logic [IdWidth-1:0]           mst_rsp_id_o,
    output logic                         mst_rsp_last_o,
    output logic                         mst_rsp_err_o,
    output logic                         irq_o,
    output logic                         rst_req_o,
    input  logic                         rst_stat_i,
    output logic [IdWidth-1:0]           fault_id_o,
    output logic [$clog2(MaxTxns+1)-1:0] outstanding_o
);

    localparam int OcWidth   = $clog2(MaxTxns + 1);
    localparam int SlotWidth = $clog2(MaxTxns);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_RESET    = 2'd2;
    localparam logic [1:0] ST_WAIT_CLR = 2'd3;

    logic [1:0]           state_q;
    logic [MaxTxns-1:0]   valid_q;
    logic [IdWidth-1:0]   id_q   [MaxTxns];
    logic [CntWidth-1:0]  age_q  [MaxTxns];
    logic [SlotWidth-1:0] rank_q [MaxTxns];
    logic [OcWidth-1:0]   count_q;
    logic                 irq_q;
    logic                 rst_req_q;
    logic [IdWidth-1:0]   fault_id_q;

    logic                 run_on;
    logic                 full;
    logic                 match_found;
    logic [SlotWidth-1:0] match_idx;
    logic [SlotWidth-1:0] match_rank;
    logic                 drain_found;
    logic [SlotWidth-1:0] drain_idx;
    logic                 alloc_found;
    logic [SlotWidth-1:0] alloc_idx;
    logic                 to_found;
    logic [SlotWidth-1:0] to_idx;
    logic                 req_hs;
    logic                 rsp_hs;
    logic                 alloc;
    logic                 free_rsp;
    logic                 free_drain;
    logic                 free_en;
    logic [SlotWidth-1:0] free_idx;
    logic [SlotWidth-1:0] free_rank;
    logic [SlotWidth-1:0] new_rank;
    logic                 fault_to;
    logic                 fault_um;

    assign run_on = (state_q == ST_RUN) && guard_ena_i;
    assign full   = (count_q == OcWidth'(MaxTxns));

    // rank_q is kept compact (0 = oldest), so the drain head is always the rank-0 slot
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        match_rank  = '0;
        drain_found = 1'b0;
        drain_idx   = '0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        to_found    = 1'b0;
        to_idx      = '0;
        for (int i = 0; i < MaxTxns; i++) begin
            if (valid_q[i] && (id_q[i] == slv_rsp_id_i) &&
                (!match_found || (rank_q[i] < match_rank))) begin
                match_found = 1'b1;
                match_idx   = SlotWidth'(i);
                match_rank  = rank_q[i];
            end
            if (valid_q[i] && (rank_q[i] == '0) && !drain_found) begin
                drain_found = 1'b1;
                drain_idx   = SlotWidth'(i);
            end
            if (!valid_q[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = SlotWidth'(i);
            end
            if (valid_q[i] && (budget_i != '0) && (age_q[i] == budget_i) && !to_found) begin
                to_found = 1'b1;
                to_idx   = SlotWidth'(i);
            end
        end
    end

    always_comb begin
        mst_req_ready_o = 1'b0;
        slv_req_valid_o = 1'b0;
        slv_rsp_ready_o = 1'b1;
        mst_rsp_valid_o = 1'b0;
        mst_rsp_id_o    = '0;
        mst_rsp_last_o  = 1'b0;
        mst_rsp_err_o   = 1'b0;
        if (state_q == ST_RUN) begin
            mst_req_ready_o = slv_req_ready_i && !(guard_ena_i && full);
            slv_req_valid_o = mst_req_valid_i && !(guard_ena_i && full);
            slv_rsp_ready_o = mst_rsp_ready_i;
            mst_rsp_valid_o = slv_rsp_valid_i;
            mst_rsp_id_o    = slv_rsp_id_i;
            mst_rsp_last_o  = slv_rsp_last_i;
        end else if (state_q == ST_DRAIN) begin
            mst_rsp_valid_o = drain_found;
            mst_rsp_id_o    = id_q[drain_idx];
            mst_rsp_last_o  = 1'b1;
            mst_rsp_err_o   = 1'b1;
        end
    end

    assign req_hs     = slv_req_valid_o && slv_req_ready_i;
    assign rsp_hs     = slv_rsp_valid_i && slv_rsp_ready_o;
    assign alloc      = run_on && req_hs && alloc_found;
    assign free_rsp   = run_on && rsp_hs && slv_rsp_last_i && match_found;
    assign free_drain = (state_q == ST_DRAIN) && mst_rsp_valid_o && mst_rsp_ready_i;
    assign free_en    = free_rsp || free_drain;
    assign free_idx   = free_drain ? drain_idx : match_idx;
    assign free_rank  = rank_q[free_idx];
    assign new_rank   = SlotWidth'(count_q - OcWidth'(free_en));
    assign fault_to   = run_on && to_found;
    assign fault_um   = run_on && rsp_hs && !match_found;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < MaxTxns; i++) begin
                id_q[i]   <= '0;
                age_q[i]  <= '0;
                rank_q[i] <= '0;
            end
        end else if ((state_q == ST_RUN) && !guard_ena_i) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < MaxTxns; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            count_q <= count_q + OcWidth'(alloc) - OcWidth'(free_en);
            for (int i = 0; i < MaxTxns; i++) begin
                if (valid_q[i] && (age_q[i] != '1)) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
                if (free_en && valid_q[i] && (rank_q[i] > free_rank)) begin
                    rank_q[i] <= rank_q[i] - 1'b1;
                end
                if (free_en && (free_idx == SlotWidth'(i))) begin
                    valid_q[i] <= 1'b0;
                end
                if (alloc && (alloc_idx == SlotWidth'(i))) begin
                    valid_q[i] <= 1'b1;
                    id_q[i]    <= mst_req_id_i;
                    age_q[i]   <= '0;
                    rank_q[i]  <= new_rank;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            irq_q      <= 1'b0;
            rst_req_q  <= 1'b0;
            fault_id_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (fault_to || fault_um) begin
                        state_q    <= ST_DRAIN;
                        irq_q      <= 1'b1;
                        fault_id_q <= fault_to ? id_q[to_idx] : slv_rsp_id_i;
                    end
                end
                ST_DRAIN: begin
                    if (count_q == '0) begin
                        state_q   <= ST_RESET;
                        rst_req_q <= 1'b1;
                    end
                end
                ST_RESET: begin
                    if (rst_stat_i) begin
                        state_q <= ST_WAIT_CLR;
                    end
                end
                ST_WAIT_CLR: begin
                    if (!rst_stat_i) begin
                        state_q    <= ST_RUN;
                        irq_q      <= 1'b0;
                        rst_req_q  <= 1'b0;
                        fault_id_q <= '0;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign irq_o         = irq_q;
    assign rst_req_o     = rst_req_q;
    assign fault_id_o    = fault_id_q;
    assign outstanding_o = count_q;

endmodule

// File: tb/tb_slv_guard_chan_monitor.sv
// Directed and randomized bench for slv_guard_chan_monitor; outstanding IDs are modelled
// as a queue in issue order, so matching frees and drain order follow from queue operations.
module tb_slv_guard_chan_monitor;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       guard_ena_i;
    logic [9:0] budget_i;
    logic       mst_req_valid_i;
    logic       mst_req_ready_o;
    logic [3:0] mst_req_id_i;
    logic       slv_req_valid_o;
    logic       slv_req_ready_i;
    logic       slv_rsp_valid_i;
    logic       slv_rsp_ready_o;
    logic [3:0] slv_rsp_id_i;
    logic       slv_rsp_last_i;
    logic       mst_rsp_valid_o;
    logic       mst_rsp_ready_i;
    logic [3:0] mst_rsp_id_o;
    logic       mst_rsp_last_o;
    logic       mst_rsp_err_o;
    logic       irq_o;
    logic       rst_req_o;
    logic       rst_stat_i;
    logic [3:0] fault_id_o;
    logic [3:0] outstanding_o;

    int n_tests = 0;
    int n_fail  = 0;
    int q[$];
    int exp_q[$];

    slv_guard_chan_monitor dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .guard_ena_i(guard_ena_i), .budget_i(budget_i),
        .mst_req_valid_i(mst_req_valid_i), .mst_req_ready_o(mst_req_ready_o),
        .mst_req_id_i(mst_req_id_i),
        .slv_req_valid_o(slv_req_valid_o), .slv_req_ready_i(slv_req_ready_i),
        .slv_rsp_valid_i(slv_rsp_valid_i), .slv_rsp_ready_o(slv_rsp_ready_o),
        .slv_rsp_id_i(slv_rsp_id_i), .slv_rsp_last_i(slv_rsp_last_i),
        .mst_rsp_valid_o(mst_rsp_valid_o), .mst_rsp_ready_i(mst_rsp_ready_i),
        .mst_rsp_id_o(mst_rsp_id_o), .mst_rsp_last_o(mst_rsp_last_o),
        .mst_rsp_err_o(mst_rsp_err_o), .irq_o(irq_o), .rst_req_o(rst_req_o),
        .rst_stat_i(rst_stat_i), .fault_id_o(fault_id_o), .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        mst_req_valid_i = 1'b0;
        mst_req_id_i    = '0;
        slv_req_ready_i = 1'b0;
        slv_rsp_valid_i = 1'b0;
        slv_rsp_id_i    = '0;
        slv_rsp_last_i  = 1'b0;
        mst_rsp_ready_i = 1'b0;
        rst_stat_i      = 1'b0;
    endtask

    task automatic issue(input int id);
        mst_req_valid_i = 1'b1;
        mst_req_id_i    = 4'(id);
        slv_req_ready_i = 1'b1;
        #1;
        chk("issue_ready", 32'(mst_req_ready_o), 32'd1);
        tick();
        mst_req_valid_i = 1'b0;
    endtask

    // manager sees one error response per queued ID, each held through two stall cycles
    task automatic drain_check(input string tag);
        mst_req_valid_i = 1'b1;
        slv_req_ready_i = 1'b1;
        while (exp_q.size() > 0) begin
            int e;
            e = exp_q.pop_front();
            mst_rsp_ready_i = 1'b0;
            for (int s = 0; s < 2; s++) begin
                #1;
                chk({tag, "_stall_valid"}, 32'(mst_rsp_valid_o), 32'd1);
                chk({tag, "_stall_id"}, 32'(mst_rsp_id_o), 32'(e));
                chk({tag, "_req_blocked"}, 32'({mst_req_ready_o, slv_req_valid_o, slv_rsp_ready_o}), 32'b001);
                tick();
            end
            mst_rsp_ready_i = 1'b1;
            #1;
            chk({tag, "_rsp"}, 32'({mst_rsp_valid_o, mst_rsp_id_o, mst_rsp_last_o, mst_rsp_err_o}),
                32'({1'b1, 4'(e), 1'b1, 1'b1}));
            tick();
        end
        mst_rsp_ready_i = 1'b1;
        #1;
        chk({tag, "_drain_done"}, 32'(mst_rsp_valid_o), 32'd0);
        idle_inputs();
    endtask

    task automatic wait_rst_req(input string tag);
        int n;
        n = 0;
        while (rst_req_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_rst_req"}, 32'(rst_req_o), 32'd1);
    endtask

    task automatic recover(input string tag);
        rst_stat_i = 1'b1;
        tick(); tick(); tick();
        chk({tag, "_still_resetting"}, 32'({irq_o, rst_req_o}), 32'b11);
        rst_stat_i = 1'b0;
        tick();
        chk({tag, "_recovered"}, 32'({irq_o, rst_req_o, fault_id_o}), 32'd0);
    endtask

    initial begin
        int free_id;
        int fired;
        logic hs;

        idle_inputs();
        rst_ni      = 1'b0;
        guard_ena_i = 1'b0;
        budget_i    = '0;
        #3;
        chk("reset_state", 32'({irq_o, rst_req_o, fault_id_o, outstanding_o}), 32'd0);
        tick(); tick();

        // full table; first request lands in the first cycle after reset release
        rst_ni      = 1'b1;
        guard_ena_i = 1'b1;
        for (int i = 0; i < 8; i++) issue(i + 1);
        chk("full_count", 32'(outstanding_o), 32'd8);
        mst_req_valid_i = 1'b1;
        mst_req_id_i    = 4'd12;
        slv_req_ready_i = 1'b1;
        slv_rsp_valid_i = 1'b1;
        slv_rsp_id_i    = 4'd1;
        slv_rsp_last_i  = 1'b1;
        mst_rsp_ready_i = 1'b1;
        #1;
        chk("full_blocks", 32'({mst_req_ready_o, slv_req_valid_o}), 32'b00);
        tick();
        slv_rsp_valid_i = 1'b0;
        chk("full_freed", 32'(outstanding_o), 32'd7);
        #1;
        chk("ninth_ready", 32'({mst_req_ready_o, slv_req_valid_o}), 32'b11);
        tick();
        chk("ninth_taken", 32'(outstanding_o), 32'd8);
        idle_inputs();
        guard_ena_i = 1'b0;
        tick();
        chk("disable_clears", 32'(outstanding_o), 32'd0);

        // pass-through with guard off
        for (int i = 0; i < 20; i++) begin
            mst_req_valid_i = 1'($urandom_range(0, 1));
            mst_req_id_i    = 4'($urandom_range(0, 15));
            slv_req_ready_i = 1'($urandom_range(0, 1));
            slv_rsp_valid_i = 1'($urandom_range(0, 1));
            slv_rsp_id_i    = 4'($urandom_range(0, 15));
            slv_rsp_last_i  = 1'($urandom_range(0, 1));
            mst_rsp_ready_i = 1'($urandom_range(0, 1));
            #1;
            chk("pass_outputs",
                32'({slv_req_valid_o, mst_req_ready_o, slv_rsp_ready_o, mst_rsp_valid_o,
                     mst_rsp_id_o, mst_rsp_last_o, mst_rsp_err_o}),
                32'({mst_req_valid_i, slv_req_ready_i, mst_rsp_ready_i, slv_rsp_valid_i,
                     slv_rsp_id_i, slv_rsp_last_i, 1'b0}));
            tick();
            chk("pass_state", 32'({outstanding_o, irq_o}), 32'd0);
        end

        // random tracking against the queue model
        idle_inputs();
        guard_ena_i = 1'b1;
        q = {};
        for (int i = 0; i < 80; i++) begin
            mst_req_valid_i = 1'($urandom_range(0, 1));
            mst_req_id_i    = 4'($urandom_range(0, 15));
            slv_req_ready_i = 1'($urandom_range(0, 1));
            mst_rsp_ready_i = 1'($urandom_range(0, 1));
            slv_rsp_valid_i = 1'b0;
            if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
                slv_rsp_valid_i = 1'b1;
                slv_rsp_id_i    = 4'(q[$urandom_range(0, q.size() - 1)]);
                slv_rsp_last_i  = 1'($urandom_range(0, 1));
            end
            #1;
            hs = slv_req_ready_i && mst_req_valid_i && (q.size() < 8);
            chk("rand_req_ready", 32'({mst_req_ready_o, slv_req_valid_o}),
                32'({slv_req_ready_i && (q.size() < 8), mst_req_valid_i && (q.size() < 8)}));
            if (slv_rsp_valid_i && mst_rsp_ready_i && slv_rsp_last_i) begin
                for (int k = 0; k < q.size(); k++) begin
                    if (q[k] == int'(slv_rsp_id_i)) begin
                        q.delete(k);
                        break;
                    end
                end
            end
            if (hs) q.push_back(int'(mst_req_id_i));
            tick();
            chk("rand_count", 32'({outstanding_o, irq_o}), 32'({4'(q.size()), 1'b0}));
        end

        // unmatched fault after the random run drains the table in issue order
        idle_inputs();
        free_id = 0;
        for (int c = 15; c >= 0; c--) begin
            int used;
            used = 0;
            foreach (q[k]) if (q[k] == c) used = 1;
            if (used == 0) free_id = c;
        end
        slv_rsp_valid_i = 1'b1;
        slv_rsp_id_i    = 4'(free_id);
        slv_rsp_last_i  = 1'b1;
        mst_rsp_ready_i = 1'b1;
        tick();
        idle_inputs();
        chk("rand_fault", 32'({irq_o, fault_id_o}), 32'({1'b1, 4'(free_id)}));
        exp_q = q;
        drain_check("rand_drain");
        wait_rst_req("rand");
        recover("rand");

        // timeout of a single ID 3
        budget_i = 10'd5;
        issue(3);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("to_early", 32'(irq_o), 32'd0);
        end
        tick();
        chk("to_fire", 32'({irq_o, fault_id_o}), 32'({1'b1, 4'd3}));
        exp_q = {3};
        drain_check("to_drain");
        wait_rst_req("to");
        recover("to");

        // drain order 1, 2, 1 after the first one times out
        issue(1);
        issue(2);
        issue(1);
        fired = 0;
        for (int k = 0; k < 20 && fired == 0; k++) begin
            if (irq_o === 1'b1) fired = 1;
            else tick();
        end
        chk("order_fault", 32'({irq_o, fault_id_o}), 32'({1'b1, 4'd1}));
        exp_q = {1, 2, 1};
        drain_check("order_drain");
        wait_rst_req("order");
        recover("order");

        // unmatched response ID 7 on an empty table
        budget_i = '0;
        slv_rsp_valid_i = 1'b1;
        slv_rsp_id_i    = 4'd7;
        slv_rsp_last_i  = 1'b1;
        mst_rsp_ready_i = 1'b1;
        tick();
        idle_inputs();
        mst_req_valid_i = 1'b1;
        slv_req_ready_i = 1'b1;
        #1;
        chk("um_fault", 32'({irq_o, fault_id_o, mst_req_ready_o}), 32'({1'b1, 4'd7, 1'b0}));
        tick();
        chk("um_rst_req", 32'(rst_req_o), 32'd1);
        idle_inputs();
        recover("um");

        // reset asserted while two error responses are pending
        issue(4);
        issue(5);
        slv_rsp_valid_i = 1'b1;
        slv_rsp_id_i    = 4'd9;
        slv_rsp_last_i  = 1'b1;
        mst_rsp_ready_i = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("mid_drain", 32'({mst_rsp_valid_o, outstanding_o, irq_o}), 32'({1'b1, 4'd2, 1'b1}));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_reset", 32'({irq_o, rst_req_o, fault_id_o, outstanding_o, mst_rsp_valid_o}), 32'd0);
        tick();
        rst_ni = 1'b1;
        mst_rsp_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("post_reset_quiet", 32'({mst_rsp_valid_o, outstanding_o, irq_o}), 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
